// File: rtl/transceiver_integration_top.sv
//============================================================================
// Module   : transceiver_integration_top / transceiver_integration
// Brief    : SPI-master bring-up sequencer for a CC1101-style transceiver.
//            Waits after reset, strobes SRES, writes the configuration ROM
//            and then polls the status register forever.
// Macro    : TRANSCEIVER_VERIFY_EN enables configuration readback/verify.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module transceiver_integration #(
  parameter int CLK_DIV        = 12,
  parameter int STARTUP_CYCLES = 4800,
  parameter int POLL_CYCLES    = 48000,
  parameter int GAP_CYCLES     = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_miso,
  output logic o_ss,
  output logic o_mosi,
  output logic o_sclk
);

  typedef enum logic [2:0] {
    ST_WAIT_START = 3'd0,
    ST_STROBE_RES = 3'd1,
    ST_WAIT_RES   = 3'd2,
    ST_CFG_WRITE  = 3'd3,
    ST_CFG_VERIFY = 3'd4,
    ST_POLL_WAIT  = 3'd5,
    ST_POLL_READ  = 3'd6
  } state_t;

  // Bit-level sub-phase of the SPI engine
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_READY = 3'd1,
    PH_LOW   = 3'd2,
    PH_HIGH  = 3'd3,
    PH_TAIL  = 3'd4,
    PH_GAP   = 3'd5
  } phase_t;

  localparam logic [15:0] c_DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] c_START_LAST = 16'(STARTUP_CYCLES - 1);
  localparam logic [15:0] c_POLL_LAST  = 16'(POLL_CYCLES - 1);
  localparam logic [15:0] c_GAP_LAST   = 16'(GAP_CYCLES - 1);
  localparam logic [7:0]  c_SRES       = 8'h30;
  localparam logic [7:0]  c_POLL_CMD   = 8'hF5;

  // Configuration ROM: {address, data}
  function automatic logic [15:0] rom_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    rom_entry = 16'h0206;
      2'd1:    rom_entry = 16'h0805;
      2'd2:    rom_entry = 16'h0B06;
      default: rom_entry = 16'h0D21;
    endcase
  endfunction

  state_t      r_state;
  phase_t      r_phase;
  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic [15:0] r_tx;
  logic [7:0]  r_rx;
  logic [3:0]  r_bits;
  logic [7:0]  r_status;
  logic        r_ss;
  logic        r_sclk;
  logic        r_mosi;

  state_t      w_target;
  logic [15:0] w_word;
  logic [3:0]  w_bits;
  logic [15:0] w_rom;
  logic [15:0] w_wait_last;
  logic        w_launch;
  logic        w_status_unused;

`ifdef TRANSCEIVER_VERIFY_EN
  logic [1:0]  r_vidx;
  logic [15:0] w_vrom;
  assign w_vrom = rom_entry(r_vidx);
`endif

  assign w_rom       = rom_entry(r_idx);
  assign w_wait_last = (r_state == ST_POLL_WAIT) ? c_POLL_LAST : c_START_LAST;
  assign w_launch    = ((r_phase == PH_IDLE) && (r_cnt == w_wait_last)) ||
                       ((r_phase == PH_GAP)  && (r_cnt == c_GAP_LAST));

  // Status byte has no pin; it is observed through the hierarchy
  assign w_status_unused = ^r_status;

  // Frame to launch next: wait states hand over to their transaction state
  always_comb begin
    w_target = r_state;
    w_word   = 16'h0000;
    w_bits   = 4'd15;
    case (r_state)
      ST_WAIT_START: w_target = ST_STROBE_RES;
      ST_WAIT_RES:   w_target = ST_CFG_WRITE;
      ST_POLL_WAIT:  w_target = ST_POLL_READ;
      default:       w_target = r_state;
    endcase
    case (w_target)
      ST_STROBE_RES: begin
        w_word = {c_SRES, 8'h00};
        w_bits = 4'd7;
      end
      ST_CFG_WRITE:  w_word = w_rom;
`ifdef TRANSCEIVER_VERIFY_EN
      ST_CFG_VERIFY: w_word = {w_vrom[15:8] | 8'h80, 8'h00};
`endif
      ST_POLL_READ:  w_word = {c_POLL_CMD, 8'h00};
      default:       w_word = 16'h0000;
    endcase
  end

  // Sequencer and SPI bit engine with registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_WAIT_START;
      r_phase  <= PH_IDLE;
      r_cnt    <= 16'd0;
      r_idx    <= 2'd0;
      r_tx     <= 16'd0;
      r_rx     <= 8'd0;
      r_bits   <= 4'd0;
      r_status <= 8'd0;
      r_ss     <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
`ifdef TRANSCEIVER_VERIFY_EN
      r_vidx   <= 2'd0;
`endif
    end else if (w_launch) begin
      // SS falls together with the first MOSI bit
      r_state <= w_target;
      r_phase <= PH_READY;
      r_ss    <= 1'b0;
      r_mosi  <= w_word[15];
      r_tx    <= {w_word[14:0], 1'b0};
      r_bits  <= w_bits;
      r_rx    <= 8'd0;
      r_cnt   <= 16'd0;
    end else begin
      case (r_phase)
        PH_IDLE, PH_GAP: r_cnt <= r_cnt + 16'd1;
        PH_READY: begin
          // MISO low means the chip is ready; unbounded wait otherwise
          if (!i_miso) begin
            r_phase <= PH_LOW;
            r_cnt   <= 16'd0;
          end
        end
        PH_LOW: begin
          if (r_cnt == c_DIV_LAST) begin
            r_sclk  <= 1'b1;
            r_rx    <= {r_rx[6:0], i_miso};
            r_phase <= PH_HIGH;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        PH_HIGH: begin
          if (r_cnt == c_DIV_LAST) begin
            r_sclk <= 1'b0;
            r_cnt  <= 16'd0;
            if (r_bits != 4'd0) begin
              r_bits  <= r_bits - 4'd1;
              r_mosi  <= r_tx[15];
              r_tx    <= {r_tx[14:0], 1'b0};
              r_phase <= PH_LOW;
            end else begin
              r_phase <= PH_TAIL;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        PH_TAIL: begin
          if (r_cnt == c_DIV_LAST) begin
            r_ss   <= 1'b1;
            r_mosi <= 1'b0;
            r_cnt  <= 16'd0;
            case (r_state)
              ST_STROBE_RES: begin
                r_state <= ST_WAIT_RES;
                r_phase <= PH_IDLE;
              end
              ST_CFG_WRITE: begin
                if (r_idx == 2'd3) begin
`ifdef TRANSCEIVER_VERIFY_EN
                  r_state <= ST_CFG_VERIFY;
                  r_vidx  <= 2'd0;
                  r_phase <= PH_GAP;
`else
                  r_state <= ST_POLL_WAIT;
                  r_phase <= PH_IDLE;
`endif
                end else begin
                  r_idx   <= r_idx + 2'd1;
                  r_phase <= PH_GAP;
                end
              end
`ifdef TRANSCEIVER_VERIFY_EN
              ST_CFG_VERIFY: begin
                if (r_rx != w_vrom[7:0]) begin
                  r_state <= ST_STROBE_RES;
                  r_idx   <= 2'd0;
                  r_phase <= PH_GAP;
                end else if (r_vidx == 2'd3) begin
                  r_state <= ST_POLL_WAIT;
                  r_phase <= PH_IDLE;
                end else begin
                  r_vidx  <= r_vidx + 2'd1;
                  r_phase <= PH_GAP;
                end
              end
`endif
              ST_POLL_READ: begin
                r_status <= r_rx;
                r_state  <= ST_POLL_WAIT;
                r_phase  <= PH_IDLE;
              end
              default: begin
                r_state <= ST_WAIT_START;
                r_phase <= PH_IDLE;
              end
            endcase
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_phase <= PH_IDLE;
      endcase
    end
  end

  assign o_ss   = r_ss;
  assign o_mosi = r_mosi;
  assign o_sclk = r_sclk;

endmodule

module transceiver_integration_top #(
  parameter int CLK_DIV        = 12,
  parameter int STARTUP_CYCLES = 4800,
  parameter int POLL_CYCLES    = 48000,
  parameter int GAP_CYCLES     = 24
) (
  input  logic CLK_48MHZ,
  input  logic BUF2_PBRST_T9,
  input  logic MISO,
  output logic SS,
  output logic MOSI,
  output logic SCLK
);

  transceiver_integration #(
    .CLK_DIV        (CLK_DIV),
    .STARTUP_CYCLES (STARTUP_CYCLES),
    .POLL_CYCLES    (POLL_CYCLES),
    .GAP_CYCLES     (GAP_CYCLES)
  ) u_core (
    .clk    (CLK_48MHZ),
    .rst_n  (BUF2_PBRST_T9),
    .i_miso (MISO),
    .o_ss   (SS),
    .o_mosi (MOSI),
    .o_sclk (SCLK)
  );

endmodule

`default_nettype wire

// File: tb/tb_transceiver_integration_top.sv
//============================================================================
// Module   : tb_transceiver_integration_top
// Brief    : Transaction-level checker for transceiver_integration_top.
//            Decodes SPI frames from the pins, answers as the transceiver
//            with random MISO data and ready stalls, and compares against
//            the expected bring-up/poll sequence. The poll interval is
//            shortened through the POLL_CYCLES parameter.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_transceiver_integration_top;

  localparam int CLK_DIV = 12;
  localparam int STARTUP = 4800;
  localparam int POLL    = 6000;
  localparam int GAP     = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic miso  = 1'b0;
  logic ss, mosi, sclk;

  int ncyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [15:0] rom [4] = '{16'h0206, 16'h0805, 16'h0B06, 16'h0D21};

  transceiver_integration_top #(
    .CLK_DIV        (CLK_DIV),
    .STARTUP_CYCLES (STARTUP),
    .POLL_CYCLES    (POLL),
    .GAP_CYCLES     (GAP)
  ) dut (
    .CLK_48MHZ     (clk),
    .BUF2_PBRST_T9 (rst_n),
    .MISO          (miso),
    .SS            (ss),
    .MOSI          (mosi),
    .SCLK          (sclk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full SPI transaction as seen from the transceiver side
  task automatic xact(input string tag, input int nbits, input logic [15:0] exp_tx,
                      input logic [15:0] miso_word, input int stall,
                      output int t_fall, output int t_rise);
    int n, wt, pulses, bad, first_rise, last_rise, last_fall;
    logic prev;
    logic [15:0] sh, got;
    wt = 0;
    while (ss !== 1'b0 && wt <= POLL + 2 * STARTUP) begin
      @(negedge clk);
      wt++;
    end
    check({tag, "_ss_fall_wait"}, 32'(ss), 32'd0);
    t_fall = ncyc;
    check({tag, "_first_bit"}, 32'(mosi), 32'(exp_tx[15]));
    miso = (stall > 0);
    sh = miso_word;
    got = 16'h0;
    n = 0; pulses = 0; bad = 0; first_rise = -1; last_rise = -1; last_fall = -1;
    prev = 1'b0;
    while (ss === 1'b0 && n < stall + 40 * CLK_DIV) begin
      @(negedge clk);
      n++;
      if (n == stall) miso = 1'b0;
      if (n == stall + 1) begin
        miso = sh[15];
        sh = sh << 1;
      end
      if (sclk && !prev) begin
        pulses++;
        got = {got[14:0], mosi};
        if (first_rise < 0) first_rise = n;
        else if (n - last_rise != 2 * CLK_DIV) bad++;
        last_rise = n;
      end
      if (!sclk && prev) begin
        if (n - last_rise != CLK_DIV) bad++;
        last_fall = n;
        if (pulses < nbits) begin
          miso = sh[15];
          sh = sh << 1;
        end
      end
      prev = sclk;
    end
    miso = 1'b0;
    t_rise = ncyc;
    check({tag, "_ss_rise"}, 32'(ss), 32'd1);
    check({tag, "_start_latency"}, 32'(first_rise), 32'(stall + CLK_DIV + 1));
    check({tag, "_pulses"}, 32'(pulses), 32'(nbits));
    check({tag, "_bit_timing_errs"}, 32'(bad), 32'd0);
    check({tag, "_tail"}, 32'(n - last_fall), 32'(CLK_DIV));
    check({tag, "_idle_sclk_mosi"}, {30'd0, sclk, mosi}, 32'd0);
    check({tag, "_mosi_frame"}, {16'd0, got}, {16'd0, exp_tx >> (16 - nbits)});
  endtask

  // Four configuration writes; first one waits out the reset recovery
  task automatic run_cfg(inout int prev);
    int tf, tr;
    for (int k = 0; k < 4; k++) begin
      xact("cfg_write", 16, rom[k], 16'($urandom),
           (k == 0) ? 100 : int'($urandom_range(0, 8)), tf, tr);
      if (k == 0) check("res_wait", 32'(tf - prev), 32'(STARTUP));
      else        check("cfg_gap_min", 32'(tf - prev >= GAP), 32'd1);
      prev = tr;
    end
  endtask

  initial begin
    int tf, tr, prev, rel, wt, npulse;
    logic was_hi;
    logic [7:0] s, d, rd;

    rst_n = 1'b0;
    miso  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("reset_pins", {29'd0, ss, sclk, mosi}, 32'b100);
    end
    rst_n = 1'b1;
    rel = ncyc;

    // Bring-up interrupted by reset in the middle of the first config write
    xact("sres", 8, 16'h3000, 16'($urandom), int'($urandom_range(0, 5)), tf, tr);
    check("startup_wait", 32'(tf - rel), 32'(STARTUP));
    prev = tr;
    wt = 0;
    while (ss !== 1'b0 && wt < 2 * STARTUP) begin
      @(negedge clk);
      wt++;
    end
    check("cfg0_start_wait", 32'(ncyc - prev), 32'(STARTUP));
    npulse = 0;
    was_hi = 1'b0;
    while (npulse < 5 && wt < 4 * STARTUP) begin
      @(negedge clk);
      wt++;
      if (sclk && !was_hi) npulse++;
      was_hi = sclk;
    end
    check("pre_reset_ss_sclk", {30'd0, ss, sclk}, 32'b01);
    #3 rst_n = 1'b0;
    #1 check("async_reset_pins", {29'd0, ss, sclk, mosi}, 32'b100);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    rel = ncyc;

    // Full sequence from WAIT_START
    xact("sres_restart", 8, 16'h3000, 16'($urandom), int'($urandom_range(0, 5)), tf, tr);
    check("restart_wait", 32'(tf - rel), 32'(STARTUP));
    prev = tr;
    run_cfg(prev);

`ifdef TRANSCEIVER_VERIFY_EN
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 4; k++) begin
        if (pass == 0 && k > 1) break;
        rd = (pass == 0 && k == 1) ? 8'h00 : rom[k][7:0];
        xact("verify_read", 16, {rom[k][15:8] | 8'h80, 8'h00}, {8'h0F, rd},
             int'($urandom_range(0, 6)), tf, tr);
        check("verify_gap_min", 32'(tf - prev >= GAP), 32'd1);
        prev = tr;
      end
      if (pass == 0) begin
        xact("reinit_sres", 8, 16'h3000, 16'h0000, 0, tf, tr);
        check("reinit_gap_min", 32'(tf - prev >= GAP), 32'd1);
        prev = tr;
        run_cfg(prev);
      end
    end
`endif

    // Status polling: first with the documented pattern, then random bytes
    for (int p = 0; p < 3; p++) begin
      s = (p == 0) ? 8'h0F : 8'($urandom);
      d = (p == 0) ? 8'hA5 : 8'($urandom);
      xact("poll", 16, 16'hF500, {s, d}, int'($urandom_range(0, 6)), tf, tr);
      check("poll_interval", 32'(tf - prev), 32'(POLL));
      check("status_reg", {24'd0, dut.u_core.r_status}, {24'd0, d});
      prev = tr;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
